// File: rtl/chksum_engine_arbiter_if.sv
// Requester-side and engine-side signal bundle of the checksum engine arbiter.
// slave = arbiter view, master = requesters plus engine (testbench) view.
interface chksum_engine_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 256,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
);
  // Handshakes: a beat/command transfers on a rising clk edge where valid & ready are both 1.
  // valid never depends on ready; payload is held stable while valid is high and ready is low.
  logic [NUM_REQ-1:0]            req_cmd_valid;
  logic [NUM_REQ-1:0]            req_cmd_ready;
  logic [NUM_REQ-1:0]            req_cmd_csum_enable;
  logic [NUM_REQ*8-1:0]          req_cmd_csum_start;
  logic [NUM_REQ*8-1:0]          req_cmd_csum_offset;
  logic [NUM_REQ*16-1:0]         req_cmd_csum_init;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_tdata;
  logic [NUM_REQ*KEEP_WIDTH-1:0] req_tkeep;
  logic [NUM_REQ-1:0]            req_tvalid;
  logic [NUM_REQ-1:0]            req_tlast;
  logic [NUM_REQ-1:0]            req_tready;
  logic [15:0]                   req_resp_csum;
  logic [NUM_REQ-1:0]            req_resp_valid;

  logic                          eng_cmd_valid;
  logic                          eng_cmd_ready;
  logic                          eng_cmd_csum_enable;
  logic [7:0]                    eng_cmd_csum_start;
  logic [7:0]                    eng_cmd_csum_offset;
  logic [15:0]                   eng_cmd_csum_init;
  logic [DATA_WIDTH-1:0]         eng_tdata;
  logic [KEEP_WIDTH-1:0]         eng_tkeep;
  logic                          eng_tvalid;
  logic                          eng_tlast;
  logic                          eng_tready;
  logic [15:0]                   eng_resp_csum;
  logic                          eng_resp_valid;
  logic                          resp_orphan_err;

  modport slave (
    input  req_cmd_valid, req_cmd_csum_enable, req_cmd_csum_start, req_cmd_csum_offset,
    input  req_cmd_csum_init, req_tdata, req_tkeep, req_tvalid, req_tlast,
    output req_cmd_ready, req_tready, req_resp_csum, req_resp_valid,
    output eng_cmd_valid, eng_cmd_csum_enable, eng_cmd_csum_start, eng_cmd_csum_offset,
    output eng_cmd_csum_init, eng_tdata, eng_tkeep, eng_tvalid, eng_tlast,
    input  eng_cmd_ready, eng_tready, eng_resp_csum, eng_resp_valid,
    output resp_orphan_err
  );

  modport master (
    output req_cmd_valid, req_cmd_csum_enable, req_cmd_csum_start, req_cmd_csum_offset,
    output req_cmd_csum_init, req_tdata, req_tkeep, req_tvalid, req_tlast,
    input  req_cmd_ready, req_tready, req_resp_csum, req_resp_valid,
    input  eng_cmd_valid, eng_cmd_csum_enable, eng_cmd_csum_start, eng_cmd_csum_offset,
    input  eng_cmd_csum_init, eng_tdata, eng_tkeep, eng_tvalid, eng_tlast,
    output eng_cmd_ready, eng_tready, eng_resp_csum, eng_resp_valid,
    input  resp_orphan_err
  );
endinterface

// File: rtl/chksum_engine_arbiter.sv
// Round-robin, packet-granular sharing of one checksum engine; an in-order tag FIFO routes results back.
// Optional CHKSUM_ARB_STATS_EN adds per-requester grant counters and a command stall counter.
module chksum_engine_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 256,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int TAG_DEPTH  = 4,
  parameter int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  chksum_engine_arbiter_if.slave bus,
  output logic                   dbg_state
`ifdef CHKSUM_ARB_STATS_EN
  ,
  output logic [NUM_REQ*32-1:0]  grant_cnt,
  output logic [31:0]            stall_cnt
`endif
);
  localparam int PTR_W = $clog2(TAG_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {ST_IDLE = 1'b0, ST_DATA = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]  grant_reg_q, grant_reg_d;
  logic [ID_W-1:0]  tag_mem_q [TAG_DEPTH];
  logic [ID_W-1:0]  tag_mem_d [TAG_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             orphan_q, orphan_d;

  logic [ID_W-1:0]  grant;
  logic             grant_found;
  logic             fifo_empty, fifo_full, pop, push, cmd_blocked, last_beat;

  assign dbg_state           = state_q;
  assign fifo_empty          = (count_q == '0);
  assign fifo_full           = (count_q == CNT_W'(TAG_DEPTH));
  assign pop                 = bus.eng_resp_valid & ~fifo_empty;
  // A same-cycle pop frees a slot, so a full FIFO only blocks commands when nothing leaves.
  assign cmd_blocked         = fifo_full & ~pop;
  assign bus.resp_orphan_err = orphan_q;
  assign bus.req_resp_csum   = bus.eng_resp_csum;

  always_comb begin : grant_sel
    int idx;
    idx         = 0;
    grant       = '0;
    grant_found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grant_found && bus.req_cmd_valid[idx]) begin
        grant_found = 1'b1;
        grant       = ID_W'(idx);
      end
    end
  end

  always_comb begin : fsm_comb
    state_d                 = state_q;
    rr_ptr_d                = rr_ptr_q;
    grant_reg_d             = grant_reg_q;
    push                    = 1'b0;
    last_beat               = 1'b0;
    bus.req_cmd_ready       = '0;
    bus.req_tready          = '0;
    bus.eng_cmd_valid       = 1'b0;
    bus.eng_cmd_csum_enable = 1'b0;
    bus.eng_cmd_csum_start  = '0;
    bus.eng_cmd_csum_offset = '0;
    bus.eng_cmd_csum_init   = '0;
    bus.eng_tdata           = '0;
    bus.eng_tkeep           = '0;
    bus.eng_tvalid          = 1'b0;
    bus.eng_tlast           = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant_found) begin
          bus.eng_cmd_valid         = bus.req_cmd_valid[grant] & ~cmd_blocked;
          bus.req_cmd_ready[grant]  = bus.eng_cmd_ready & ~cmd_blocked;
          bus.eng_cmd_csum_enable   = bus.req_cmd_csum_enable[grant];
          bus.eng_cmd_csum_start    = bus.req_cmd_csum_start[int'(grant)*8 +: 8];
          bus.eng_cmd_csum_offset   = bus.req_cmd_csum_offset[int'(grant)*8 +: 8];
          bus.eng_cmd_csum_init     = bus.req_cmd_csum_init[int'(grant)*16 +: 16];
        end
        push = bus.eng_cmd_valid & bus.eng_cmd_ready;
        if (push) begin
          grant_reg_d = grant;
          state_d     = ST_DATA;
        end
      end
      ST_DATA: begin
        bus.eng_tdata                = bus.req_tdata[int'(grant_reg_q)*DATA_WIDTH +: DATA_WIDTH];
        bus.eng_tkeep                = bus.req_tkeep[int'(grant_reg_q)*KEEP_WIDTH +: KEEP_WIDTH];
        bus.eng_tvalid               = bus.req_tvalid[grant_reg_q];
        bus.eng_tlast                = bus.req_tlast[grant_reg_q];
        bus.req_tready[grant_reg_q]  = bus.eng_tready;
        last_beat = bus.eng_tvalid & bus.eng_tready & bus.eng_tlast;
        if (last_beat) begin
          rr_ptr_d = (grant_reg_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_reg_q + ID_W'(1);
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin : tag_fifo_comb
    tag_mem_d          = tag_mem_q;
    wr_ptr_d           = wr_ptr_q;
    rd_ptr_d           = rd_ptr_q;
    count_d            = count_q;
    orphan_d           = orphan_q | (bus.eng_resp_valid & fifo_empty);
    bus.req_resp_valid = '0;
    if (push) begin
      tag_mem_d[wr_ptr_q] = grant;
      wr_ptr_d            = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      bus.req_resp_valid[tag_mem_q[rd_ptr_q]] = 1'b1;
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      grant_reg_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      orphan_q    <= 1'b0;
      for (int i = 0; i < TAG_DEPTH; i++) tag_mem_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_reg_q <= grant_reg_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      orphan_q    <= orphan_d;
      tag_mem_q   <= tag_mem_d;
    end
  end

`ifdef CHKSUM_ARB_STATS_EN
  logic [31:0] grant_cnt_q [NUM_REQ];
  logic [31:0] grant_cnt_d [NUM_REQ];
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin : stats_comb
    grant_cnt_d = grant_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (last_beat) grant_cnt_d[grant_reg_q] = grant_cnt_q[grant_reg_q] + 32'd1;
    if (state_q == ST_IDLE && |bus.req_cmd_valid && (cmd_blocked || !bus.eng_cmd_ready))
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      for (int i = 0; i < NUM_REQ; i++) grant_cnt_q[i] <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      grant_cnt_q <= grant_cnt_d;
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant_cnt
    assign grant_cnt[gi*32 +: 32] = grant_cnt_q[gi];
  end
  assign stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_chksum_engine_arbiter.sv
// Directed bench for chksum_engine_arbiter: queue-based reference model compared every cycle,
// plus hand-computed expectations for grant order, routing, FIFO-full blocking, orphans and reset.
module tb_chksum_engine_arbiter;
  localparam int NR   = 2;
  localparam int DW   = 256;
  localparam int KW   = DW / 8;
  localparam int TD   = 4;
  localparam int ID_W = 1;

  logic clk;
  logic rst_n;
  logic dbg_state;
`ifdef CHKSUM_ARB_STATS_EN
  logic [NR*32-1:0] grant_cnt;
  logic [31:0]      stall_cnt;
`endif

  chksum_engine_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .KEEP_WIDTH(KW)) bus ();

  chksum_engine_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .TAG_DEPTH(TD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
`ifdef CHKSUM_ARB_STATS_EN
    ,
    .grant_cnt (grant_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- bookkeeping ----------------
  int n_checks;
  int n_err;
  int glog[$];
  int rlog[$];
  int n_eng_beats;
  int n_eng_cmds;

  // reference model state
  bit              m_busy;
  int              m_owner;
  int              m_rr;
  logic [ID_W-1:0] exp_q[$];
  bit              m_orph;
  int              m_gcnt[NR];
  int              m_stall;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic to_fail(input string nm);
    n_checks++;
    n_err++;
    $display("FAIL %s: wait bound expired (t=%0t)", nm, $time);
  endtask

  task automatic cmp_log(input string nm, input int act[$], input int exp[$]);
    chk({nm, "_len"}, DW'(act.size()), DW'(exp.size()));
    for (int i = 0; i < exp.size(); i++)
      if (i < act.size()) chk(nm, DW'(act[i]), DW'(exp[i]));
  endtask

  // ---------------- reference model + per-cycle compare ----------------
  task automatic model_loop();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_busy = 0; m_owner = 0; m_rr = 0; m_orph = 0; m_stall = 0;
        exp_q.delete();
        for (int r = 0; r < NR; r++) m_gcnt[r] = 0;
      end else begin : cmp
        int g;
        bit found, pop, blk;
        logic [NR-1:0] e_cready, e_tready, e_rv;
        logic e_cv, e_tv;
        found = 0; g = 0;
        for (int i = 0; i < NR; i++)
          if (!found && bus.req_cmd_valid[(m_rr + i) % NR]) begin
            found = 1; g = (m_rr + i) % NR;
          end
        pop = bus.eng_resp_valid && exp_q.size() > 0;
        blk = (exp_q.size() == TD) && !pop;
        e_cready = '0; e_tready = '0; e_cv = 0; e_tv = 0;
        if (!m_busy) begin
          if (found) begin
            e_cv = !blk;
            e_cready[g] = bus.eng_cmd_ready && !blk;
          end
        end else begin
          e_tv = bus.req_tvalid[m_owner];
          e_tready[m_owner] = bus.eng_tready;
        end
        e_rv = pop ? (NR'(1) << exp_q[0]) : '0;

        chk("req_cmd_ready", DW'(bus.req_cmd_ready), DW'(e_cready));
        chk("eng_cmd_valid", DW'(bus.eng_cmd_valid), DW'(e_cv));
        chk("req_tready", DW'(bus.req_tready), DW'(e_tready));
        chk("eng_tvalid", DW'(bus.eng_tvalid), DW'(e_tv));
        chk("req_resp_valid", DW'(bus.req_resp_valid), DW'(e_rv));
        chk("resp_orphan_err", DW'(bus.resp_orphan_err), DW'(m_orph));
        if (e_cv) begin
          chk("cmd_enable", DW'(bus.eng_cmd_csum_enable), DW'(bus.req_cmd_csum_enable[g]));
          chk("cmd_start", DW'(bus.eng_cmd_csum_start), DW'(bus.req_cmd_csum_start[g*8 +: 8]));
          chk("cmd_offset", DW'(bus.eng_cmd_csum_offset), DW'(bus.req_cmd_csum_offset[g*8 +: 8]));
          chk("cmd_init", DW'(bus.eng_cmd_csum_init), DW'(bus.req_cmd_csum_init[g*16 +: 16]));
        end
        if (e_tv) begin
          chk("eng_tdata", bus.eng_tdata, bus.req_tdata[m_owner*DW +: DW]);
          chk("eng_tkeep", DW'(bus.eng_tkeep), DW'(bus.req_tkeep[m_owner*KW +: KW]));
          chk("eng_tlast", DW'(bus.eng_tlast), DW'(bus.req_tlast[m_owner]));
        end
        if (pop) chk("req_resp_csum", DW'(bus.req_resp_csum), DW'(bus.eng_resp_csum));
`ifdef CHKSUM_ARB_STATS_EN
        for (int r = 0; r < NR; r++) chk("grant_cnt", DW'(grant_cnt[r*32 +: 32]), DW'(m_gcnt[r]));
        chk("stall_cnt", DW'(stall_cnt), DW'(m_stall));
`endif
        // observation logs for the literal checks
        if (bus.eng_cmd_valid && bus.eng_cmd_ready) begin
          glog.push_back(bus.req_cmd_ready[1] ? 1 : 0);
          n_eng_cmds++;
        end
        if (bus.eng_tvalid && bus.eng_tready) n_eng_beats++;
        if (bus.req_resp_valid != '0) rlog.push_back(int'(bus.req_resp_valid));

        // advance the model to the state after this clock edge
        if (!m_busy && |bus.req_cmd_valid && (blk || !bus.eng_cmd_ready)) m_stall++;
        if (pop) void'(exp_q.pop_front());
        else if (bus.eng_resp_valid) m_orph = 1;
        if (!m_busy && e_cv && bus.eng_cmd_ready) begin
          exp_q.push_back(ID_W'(g));
          m_busy = 1; m_owner = g;
        end else if (m_busy && e_tv && bus.eng_tready && bus.req_tlast[m_owner]) begin
          m_gcnt[m_owner]++;
          m_rr = (m_owner + 1) % NR;
          m_busy = 0;
        end
      end
    end
  endtask

  // ---------------- driver tasks (called at posedge + 1) ----------------
  task automatic send_pkt(input int r, input int nb, input logic [15:0] init);
    int t;
    bus.req_cmd_valid[r]          = 1'b1;
    bus.req_cmd_csum_enable[r]    = init[0];
    bus.req_cmd_csum_start[r*8 +: 8]  = init[7:0] + 8'(r);
    bus.req_cmd_csum_offset[r*8 +: 8] = init[15:8];
    bus.req_cmd_csum_init[r*16 +: 16] = init;
    t = 0;
    @(negedge clk);
    while (!bus.req_cmd_ready[r] && t < 300) begin @(negedge clk); t++; end
    if (t >= 300) to_fail("cmd_wait");
    @(posedge clk); #1;
    bus.req_cmd_valid[r] = 1'b0;
    for (int b = 0; b < nb; b++) begin
      bus.req_tvalid[r]          = 1'b1;
      bus.req_tlast[r]           = (b == nb - 1);
      bus.req_tdata[r*DW +: DW]  = {224'(r * 100 + b), 16'(b), init};
      bus.req_tkeep[r*KW +: KW]  = {KW{1'b1}} >> b;
      t = 0;
      @(negedge clk);
      while (!bus.req_tready[r] && t < 300) begin @(negedge clk); t++; end
      if (t >= 300) to_fail("beat_wait");
      @(posedge clk); #1;
    end
    bus.req_tvalid[r] = 1'b0;
    bus.req_tlast[r]  = 1'b0;
  endtask

  task automatic send_resp(input logic [15:0] c);
    bus.eng_resp_valid = 1'b1;
    bus.eng_resp_csum  = c;
    @(posedge clk); #1;
    bus.eng_resp_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_glog(input int n);
    int t;
    t = 0;
    while (glog.size() < n && t < 300) begin @(negedge clk); t++; end
    if (t >= 300) to_fail("grant_wait");
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int e[$];
    int b0, c0;
    n_checks = 0; n_err = 0; n_eng_beats = 0; n_eng_cmds = 0;
    rst_n = 1'b0;
    bus.req_cmd_valid = '0; bus.req_cmd_csum_enable = '0; bus.req_cmd_csum_start = '0;
    bus.req_cmd_csum_offset = '0; bus.req_cmd_csum_init = '0;
    bus.req_tdata = '0; bus.req_tkeep = '0; bus.req_tvalid = '0; bus.req_tlast = '0;
    bus.eng_cmd_ready = 1'b1; bus.eng_tready = 1'b1;
    bus.eng_resp_csum = '0; bus.eng_resp_valid = 1'b0;
    fork model_loop(); join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_state", DW'(dbg_state), DW'(0));
    chk("rst_cmd_ready", DW'(bus.req_cmd_ready), DW'(0));
    chk("rst_tready", DW'(bus.req_tready), DW'(0));
    chk("rst_eng_cmd_valid", DW'(bus.eng_cmd_valid), DW'(0));
    chk("rst_orphan", DW'(bus.resp_orphan_err), DW'(0));
    @(posedge clk); #1 rst_n = 1'b1;

    // single requester, engine command stall, 3 beats, result 0xBEEF
    b0 = n_eng_beats; c0 = n_eng_cmds;
    fork
      send_pkt(0, 3, 16'h1111);
      begin
        bus.eng_cmd_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 bus.eng_cmd_ready = 1'b1;
      end
    join
    chk("t1_cmds", DW'(n_eng_cmds - c0), DW'(1));
    chk("t1_beats", DW'(n_eng_beats - b0), DW'(3));
    fork
      send_resp(16'hBEEF);
      begin
        @(negedge clk);
        chk("t1_resp_valid", DW'(bus.req_resp_valid), DW'(2'b01));
        chk("t1_resp_csum", DW'(bus.req_resp_csum), DW'(16'hBEEF));
      end
    join

    // contention straight from reset; req0 re-requests at its tlast and loses to req1
    do_reset();
    glog.delete(); rlog.delete();
    fork
      begin send_pkt(0, 2, 16'h2001); send_pkt(0, 1, 16'h2003); end
      send_pkt(1, 2, 16'h2102);
    join
    e = '{0, 1, 0};
    cmp_log("t2_grant_order", glog, e);
    send_resp(16'h0A01); send_resp(16'h0A02); send_resp(16'h0A03);
    e = '{1, 2, 1};
    cmp_log("t2_resp_route", rlog, e);

    // req1 mid-packet (with a tready gap) while req0 waits
    glog.delete(); rlog.delete();
    fork
      send_pkt(1, 4, 16'h3100);
      begin
        repeat (2) @(posedge clk);
        #1 send_pkt(0, 1, 16'h3001);
      end
      begin
        repeat (3) @(posedge clk);
        #1 bus.eng_tready = 1'b0;
        repeat (2) @(posedge clk);
        #1 bus.eng_tready = 1'b1;
      end
    join
    e = '{1, 0};
    cmp_log("t3_grant_order", glog, e);
    send_resp(16'h0B01); send_resp(16'h0B02);
    e = '{2, 1};
    cmp_log("t3_resp_route", rlog, e);

    // tag FIFO full: five one-beat packets, engine withholds results
    glog.delete(); rlog.delete();
    fork
      begin
        send_pkt(0, 1, 16'h4000); send_pkt(1, 1, 16'h4101); send_pkt(0, 1, 16'h4002);
        send_pkt(1, 1, 16'h4103); send_pkt(0, 1, 16'h4004);
      end
      begin
        wait_glog(4);
        repeat (5) @(negedge clk);
        chk("t4_full_eng_cmd_valid", DW'(bus.eng_cmd_valid), DW'(0));
        chk("t4_full_cmd_ready", DW'(bus.req_cmd_ready), DW'(0));
        chk("t4_full_grants", DW'(glog.size()), DW'(4));
        @(posedge clk); #1;
        send_resp(16'hA001);
        wait_glog(5);
        @(posedge clk); #1;
        send_resp(16'hA002); send_resp(16'hA003); send_resp(16'hA004); send_resp(16'hA005);
      end
    join
    e = '{0, 1, 0, 1, 0};
    cmp_log("t4_grant_order", glog, e);
    e = '{1, 2, 1, 2, 1};
    cmp_log("t4_resp_route", rlog, e);

    // orphan result with an empty FIFO
    fork
      send_resp(16'hDEAD);
      begin
        @(negedge clk);
        chk("t5_orphan_no_valid", DW'(bus.req_resp_valid), DW'(0));
      end
    join
    @(negedge clk);
    chk("t5_orphan_set", DW'(bus.resp_orphan_err), DW'(1));
    repeat (8) @(negedge clk);
    chk("t5_orphan_sticky", DW'(bus.resp_orphan_err), DW'(1));
    @(posedge clk); #1;
    do_reset();
    @(negedge clk);
    chk("t5_orphan_cleared", DW'(bus.resp_orphan_err), DW'(0));

    // reset while the second data beat is presented
    @(posedge clk); #1;
    bus.req_cmd_valid[1] = 1'b1;
    bus.req_cmd_csum_init[16 +: 16] = 16'h6100;
    @(negedge clk);
    if (!bus.req_cmd_ready[1]) to_fail("t6_cmd_wait");
    @(posedge clk); #1;
    bus.req_cmd_valid[1] = 1'b0;
    bus.req_tvalid[1] = 1'b1;
    bus.req_tdata[DW +: DW] = DW'(256'h600);
    @(posedge clk); #1;
    bus.req_tdata[DW +: DW] = DW'(256'h601);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.req_tvalid[1] = 1'b0;
    @(negedge clk);
    chk("t6_state_idle", DW'(dbg_state), DW'(0));
    chk("t6_tready_zero", DW'(bus.req_tready), DW'(0));
    chk("t6_cmd_ready_zero", DW'(bus.req_cmd_ready), DW'(0));
    chk("t6_eng_tvalid_zero", DW'(bus.eng_tvalid), DW'(0));
`ifdef CHKSUM_ARB_STATS_EN
    chk("t6_grant_cnt_zero", DW'(grant_cnt), DW'(0));
    chk("t6_stall_cnt_zero", DW'(stall_cnt), DW'(0));
`endif
    @(posedge clk); #1;
    fork
      send_resp(16'h5555);
      begin
        @(negedge clk);
        chk("t6_flushed_no_valid", DW'(bus.req_resp_valid), DW'(0));
      end
    join
    @(negedge clk);
    chk("t6_flushed_orphan", DW'(bus.resp_orphan_err), DW'(1));

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
